// File: rtl/get_4_isog_input_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// get_4_isog_input_loader : word-serial loader for X4_0/X4_1/Z4_0/Z4_1, then
// kicks the get_4_isog controller and reports done.
// Option macro: GET_4_ISOG_LOADER_CHECKSUM_EN (adds XOR checksum output).
// Revision 1.0
// ----------------------------------------------------------------------------
module get_4_isog_input_loader #(
  parameter  int RADIX      = 32,
  parameter  int WIDTH_REAL = 14,
  localparam int ADDR_W     = $clog2(WIDTH_REAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RADIX-1:0]  in_data,
  input  logic              in_last,
  output logic              mem_X4_0_wr_en,
  output logic              mem_X4_1_wr_en,
  output logic              mem_Z4_0_wr_en,
  output logic              mem_Z4_1_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [RADIX-1:0]  mem_din,
  output logic              ctrl_start,
`ifdef GET_4_ISOG_LOADER_CHECKSUM_EN
  output logic [RADIX-1:0]  checksum,
`endif
  input  logic              ctrl_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WIDTH_REAL - 1);

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        sel;
  logic [3:0]        wr_en;
  logic              accept;
  logic              final_beat;

  assign accept     = in_valid & in_ready;
  assign final_beat = (sel == 2'd3) && (word_cnt == LAST_WORD);

  assign mem_X4_0_wr_en = wr_en[0];
  assign mem_X4_1_wr_en = wr_en[1];
  assign mem_Z4_0_wr_en = wr_en[2];
  assign mem_Z4_1_wr_en = wr_en[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      in_ready    <= 1'b0;
      wr_en       <= '0;
      mem_wr_addr <= '0;
      mem_din     <= '0;
      ctrl_start  <= 1'b0;
      word_cnt    <= '0;
      sel         <= 2'd0;
`ifdef GET_4_ISOG_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      wr_en      <= '0;
      ctrl_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            error    <= 1'b0;
            word_cnt <= '0;
            sel      <= 2'd0;
`ifdef GET_4_ISOG_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_en[sel]  <= 1'b1;
            mem_wr_addr <= word_cnt;
            mem_din     <= in_data;
`ifdef GET_4_ISOG_LOADER_CHECKSUM_EN
            checksum    <= checksum ^ in_data;
`endif
            // Framing errors are flagged but never abort the load.
            if (final_beat) begin
              if (!in_last) error <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_KICK;
            end else begin
              if (in_last) error <= 1'b1;
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                sel      <= sel + 2'd1;
              end else begin
                word_cnt <= word_cnt + ADDR_W'(1);
              end
            end
          end
        end
        // KICK lets the final strobe land before the controller starts.
        S_KICK: begin
          ctrl_start <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (ctrl_done) begin
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
